// File: rtl/operand_scoreboard_pkg.sv
// Shared types and constants for the decode-stage operand scoreboard.
//   reg_idx_t : architectural register index (x0..x31)
//   fwd_src_t : which source an operand is resolved from
//   CNT_W     : width of each per-register pending-writer counter
//   NREG      : number of architectural integer registers
package operand_scoreboard_pkg;

   localparam int unsigned NREG  = 32;
   localparam int unsigned CNT_W = 2;

   typedef logic [4:0] reg_idx_t;

   typedef enum logic [2:0] {
      FWD_NONE,
      FWD_EX,
      FWD_MEM,
      FWD_WB,
      FWD_RF
   } fwd_src_t;

endpackage

// File: rtl/operand_fwd_sel.sv
// Resolves one source operand from the youngest visible writer.
// Ports:
//   src, use_src, rf_data          : source index, read enable, register-file value
//   ex_*/mem_*                     : writer in EX / MEM, its rd, readiness and result
//   wb_valid, wb_rd, wb_data       : retiring write this cycle
//   pending                        : a write to src is still in flight somewhere
//   value, bubble                  : resolved operand and "not yet available" flag
module operand_fwd_sel
   import operand_scoreboard_pkg::*;
(
   input  reg_idx_t    src,
   input  logic        use_src,
   input  logic [63:0] rf_data,
   input  logic        ex_match_valid,
   input  reg_idx_t    ex_rd,
   input  logic        ex_ready,
   input  logic [63:0] ex_data,
   input  logic        mem_match_valid,
   input  reg_idx_t    mem_rd,
   input  logic        mem_ready,
   input  logic [63:0] mem_data,
   input  logic        wb_valid,
   input  reg_idx_t    wb_rd,
   input  logic [63:0] wb_data,
   input  logic        pending,
   output logic [63:0] value,
   output logic        bubble
);

   fwd_src_t sel;
   logic     stall;

   // Priority follows pipeline age: the youngest writer (EX) shadows older ones.
   always_comb begin
      sel   = FWD_RF;
      stall = 1'b0;
      if (src == '0) begin
         sel = FWD_NONE;
      end else if (ex_match_valid && ex_rd == src) begin
         sel   = FWD_EX;
         stall = ~ex_ready;
      end else if (mem_match_valid && mem_rd == src) begin
         sel   = FWD_MEM;
         stall = ~mem_ready;
      end else if (wb_valid && wb_rd == src) begin
         sel = FWD_WB;
      end else if (pending) begin
         // Writer is upstream of the visible stages; no value to forward yet.
         stall = 1'b1;
      end
   end

   // A stalled operand still drives the RF value so downstream muxes never see X.
   always_comb begin
      value = rf_data;
      unique case (sel)
         FWD_NONE: value = '0;
         FWD_EX:   value = ex_ready  ? ex_data  : rf_data;
         FWD_MEM:  value = mem_ready ? mem_data : rf_data;
         FWD_WB:   value = wb_data;
         FWD_RF:   value = rf_data;
         default:  value = rf_data;
      endcase
   end

   assign bubble = stall & use_src;

endmodule

// File: rtl/operand_scoreboard.sv
// Decode-stage operand scoreboard: per-register pending-writer counters plus
// EX/MEM/WB forwarding for two source operands.
// Ports:
//   clk, reset (sync, active-low)
//   rs1/rs2, use_rs1/use_rs2, rf_rd1/rf_rd2 : decode sources and RF read data
//   issue_valid/issue_wen/issue_rd          : instruction leaving decode
//   ex_*, mem_*, wb_*                       : downstream writers and retiring write
//   flush                                   : kill everything not yet in WB
//   scra/scrb, bubble1/bubble2              : resolved operands and hazard flags
//   sb_full                                 : issue_rd counter saturated, decode holds
module operand_scoreboard
   import operand_scoreboard_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  reg_idx_t    rs1,
   input  reg_idx_t    rs2,
   input  logic        use_rs1,
   input  logic        use_rs2,
   input  logic [63:0] rf_rd1,
   input  logic [63:0] rf_rd2,
   input  logic        issue_valid,
   input  logic        issue_wen,
   input  reg_idx_t    issue_rd,
   input  logic        ex_match_valid,
   input  reg_idx_t    ex_rd,
   input  logic        ex_ready,
   input  logic [63:0] ex_data,
   input  logic        mem_match_valid,
   input  reg_idx_t    mem_rd,
   input  logic        mem_ready,
   input  logic [63:0] mem_data,
   input  logic        wb_valid,
   input  reg_idx_t    wb_rd,
   input  logic [63:0] wb_data,
   input  logic        flush,
   output logic [63:0] scra,
   output logic [63:0] scrb,
   output logic        bubble1,
   output logic        bubble2,
   output logic        sb_full
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [CNT_W-1:0] pending_q [NREG];
   logic [CNT_W-1:0] pending_d [NREG];
   logic             inc;
   logic             dec;

   assign sb_full = issue_wen && (issue_rd != '0) && (pending_q[issue_rd] == CntMax);
   assign inc     = issue_valid && issue_wen && (issue_rd != '0) && !sb_full && !flush;
   assign dec     = wb_valid && (wb_rd != '0);

   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         pending_d[i] = pending_q[i];
      end
      if (!flush) begin
         for (int i = 1; i < NREG; i++) begin
            if (inc && !(dec && wb_rd == reg_idx_t'(i)) && issue_rd == reg_idx_t'(i)) begin
               pending_d[i] = pending_q[i] + CNT_W'(1);
            end else if (dec && !(inc && issue_rd == reg_idx_t'(i)) && wb_rd == reg_idx_t'(i)
                         && pending_q[i] != '0) begin
               pending_d[i] = pending_q[i] - CNT_W'(1);
            end
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            pending_d[i] = '0;
         end
      end
      // x0 never has a writer.
      pending_d[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            pending_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            pending_q[i] <= pending_d[i];
         end
      end
   end

   // A retiring write to a register with no recorded writer means bookkeeping is broken.
   assert property (@(posedge clk) disable iff (!reset)
                    (dec && !flush && !(inc && issue_rd == wb_rd)) |-> pending_q[wb_rd] != '0)
      else $error("operand_scoreboard: writeback to register with zero pending count");

   operand_fwd_sel u_fwd_a (
      .src             (rs1),
      .use_src         (use_rs1),
      .rf_data         (rf_rd1),
      .ex_match_valid  (ex_match_valid),
      .ex_rd           (ex_rd),
      .ex_ready        (ex_ready),
      .ex_data         (ex_data),
      .mem_match_valid (mem_match_valid),
      .mem_rd          (mem_rd),
      .mem_ready       (mem_ready),
      .mem_data        (mem_data),
      .wb_valid        (wb_valid),
      .wb_rd           (wb_rd),
      .wb_data         (wb_data),
      .pending         (pending_q[rs1] != '0),
      .value           (scra),
      .bubble          (bubble1)
   );

   operand_fwd_sel u_fwd_b (
      .src             (rs2),
      .use_src         (use_rs2),
      .rf_data         (rf_rd2),
      .ex_match_valid  (ex_match_valid),
      .ex_rd           (ex_rd),
      .ex_ready        (ex_ready),
      .ex_data         (ex_data),
      .mem_match_valid (mem_match_valid),
      .mem_rd          (mem_rd),
      .mem_ready       (mem_ready),
      .mem_data        (mem_data),
      .wb_valid        (wb_valid),
      .wb_rd           (wb_rd),
      .wb_data         (wb_data),
      .pending         (pending_q[rs2] != '0),
      .value           (scrb),
      .bubble          (bubble2)
   );

endmodule

// File: tb/tb_operand_scoreboard.sv
// Self-checking bench for operand_scoreboard: expected outputs are queued as
// stimulus is driven and popped/compared once the combinational outputs settle.
module tb_operand_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1, rs2, issue_rd, ex_rd, mem_rd, wb_rd;
   logic        use_rs1, use_rs2, issue_valid, issue_wen;
   logic [63:0] rf_rd1, rf_rd2, ex_data, mem_data, wb_data;
   logic        ex_match_valid, ex_ready, mem_match_valid, mem_ready, wb_valid, flush;
   logic [63:0] scra, scrb;
   logic        bubble1, bubble2, sb_full;

   always #5 clk = ~clk;

   operand_scoreboard dut (
      .clk             (clk),
      .reset           (reset),
      .rs1             (rs1),
      .rs2             (rs2),
      .use_rs1         (use_rs1),
      .use_rs2         (use_rs2),
      .rf_rd1          (rf_rd1),
      .rf_rd2          (rf_rd2),
      .issue_valid     (issue_valid),
      .issue_wen       (issue_wen),
      .issue_rd        (issue_rd),
      .ex_match_valid  (ex_match_valid),
      .ex_rd           (ex_rd),
      .ex_ready        (ex_ready),
      .ex_data         (ex_data),
      .mem_match_valid (mem_match_valid),
      .mem_rd          (mem_rd),
      .mem_ready       (mem_ready),
      .mem_data        (mem_data),
      .wb_valid        (wb_valid),
      .wb_rd           (wb_rd),
      .wb_data         (wb_data),
      .flush           (flush),
      .scra            (scra),
      .scrb            (scrb),
      .bubble1         (bubble1),
      .bubble2         (bubble2),
      .sb_full         (sb_full)
   );

   typedef struct {
      string       tag;
      logic [63:0] scra;
      logic [63:0] scrb;
      logic        b1;
      logic        b2;
      logic        full;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [63:0] a, input logic [63:0] b,
                             input logic b1, input logic b2, input logic full);
      exp_t e;
      e.tag = tag; e.scra = a; e.scrb = b; e.b1 = b1; e.b2 = b2; e.full = full;
      sb_q.push_back(e);
   endtask

   // Outputs are combinational: let them settle mid-phase, then drain the queue.
   task automatic compare_out();
      exp_t e;
      #2;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_eq({e.tag, ".scra"},    scra,    e.scra);
         check_eq({e.tag, ".scrb"},    scrb,    e.scrb);
         check_eq({e.tag, ".bubble1"}, 64'(bubble1), 64'(e.b1));
         check_eq({e.tag, ".bubble2"}, 64'(bubble2), 64'(e.b2));
         check_eq({e.tag, ".sb_full"}, 64'(sb_full), 64'(e.full));
      end
   endtask

   // Start a new cycle at the falling edge with quiet defaults.
   task automatic step();
      @(negedge clk);
      rs1 = 5'd5;  rs2 = 5'd6;  use_rs1 = 1'b1; use_rs2 = 1'b1;
      rf_rd1 = 64'h11; rf_rd2 = 64'h22;
      issue_valid = 1'b0; issue_wen = 1'b0; issue_rd = '0;
      ex_match_valid = 1'b0; ex_rd = '0; ex_ready = 1'b0; ex_data = '0;
      mem_match_valid = 1'b0; mem_rd = '0; mem_ready = 1'b0; mem_data = '0;
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd);
      issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = rd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      step();
      repeat (2) @(posedge clk);
      step();
      reset = 1'b1;
      expect_out("reset", 64'h11, 64'h22, 1'b0, 1'b0, 1'b0);
      compare_out();

      // Every counter clear: no source is bubbled.
      for (int s = 1; s < 32; s++) begin
         step();
         rs1 = 5'(s); rf_rd1 = 64'h100 + 64'(s);
         issue_wen = 1'b1; issue_rd = 5'(s);
         expect_out($sformatf("clear%0d", s), 64'h100 + 64'(s), 64'h22, 1'b0, 1'b0, 1'b0);
         compare_out();
      end

      // Issue rd=7, then bubble until WB forwards.
      step(); issue(5'd7);
      expect_out("iss7", 64'h11, 64'h22, 1'b0, 1'b0, 1'b0); compare_out();
      step(); rs1 = 5'd7; rf_rd1 = 64'h55;
      expect_out("pend7", 64'h55, 64'h22, 1'b1, 1'b0, 1'b0); compare_out();
      step(); rs1 = 5'd7; rf_rd1 = 64'h55; wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'hAB;
      expect_out("wb7", 64'hAB, 64'h22, 1'b0, 1'b0, 1'b0); compare_out();
      step(); rs1 = 5'd7; rf_rd1 = 64'h55;
      expect_out("done7", 64'h55, 64'h22, 1'b0, 1'b0, 1'b0); compare_out();

      // EX shadows MEM; readiness controls bubble.
      step(); rs2 = 5'd3; rf_rd2 = 64'h33;
      ex_match_valid = 1'b1; ex_rd = 5'd3; ex_ready = 1'b1; ex_data = 64'h1;
      mem_match_valid = 1'b1; mem_rd = 5'd3; mem_ready = 1'b1; mem_data = 64'h2;
      expect_out("ex_fwd", 64'h11, 64'h1, 1'b0, 1'b0, 1'b0); compare_out();
      ex_ready = 1'b0;
      expect_out("ex_nrdy", 64'h11, 64'h33, 1'b0, 1'b1, 1'b0); compare_out();
      ex_match_valid = 1'b0;
      expect_out("mem_fwd", 64'h11, 64'h2, 1'b0, 1'b0, 1'b0); compare_out();
      mem_ready = 1'b0;
      expect_out("mem_nrdy", 64'h11, 64'h33, 1'b0, 1'b1, 1'b0); compare_out();

      // Saturate rd=9.
      for (int k = 0; k < 3; k++) begin
         step(); issue(5'd9);
         expect_out($sformatf("iss9_%0d", k), 64'h11, 64'h22, 1'b0, 1'b0, 1'b0); compare_out();
      end
      step(); issue(5'd9);
      expect_out("full9", 64'h11, 64'h22, 1'b0, 1'b0, 1'b1); compare_out();
      step(); issue_wen = 1'b1; issue_rd = 5'd9;
      expect_out("stay3", 64'h11, 64'h22, 1'b0, 1'b0, 1'b1); compare_out();
      step(); wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 64'h99;
      expect_out("wb9a", 64'h11, 64'h22, 1'b0, 1'b0, 1'b0); compare_out();
      step(); issue(5'd9); wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 64'h99;
      expect_out("incdec9", 64'h11, 64'h22, 1'b0, 1'b0, 1'b0); compare_out();
      step(); issue_wen = 1'b1; issue_rd = 5'd9;
      expect_out("cnt2", 64'h11, 64'h22, 1'b0, 1'b0, 1'b0); compare_out();
      for (int k = 0; k < 2; k++) begin
         step(); wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 64'h99;
      end
      step(); rs1 = 5'd9; rf_rd1 = 64'h90;
      expect_out("last9", 64'h90, 64'h22, 1'b0, 1'b0, 1'b0); compare_out();

      // x0 ignores forwarding; unused source never bubbles.
      step(); issue(5'd12);
      rs1 = 5'd0; ex_match_valid = 1'b1; ex_rd = 5'd0; ex_ready = 1'b1; ex_data = 64'hFF;
      expect_out("x0", 64'h0, 64'h22, 1'b0, 1'b0, 1'b0); compare_out();
      step(); rs2 = 5'd12; rf_rd2 = 64'hC0; use_rs2 = 1'b0;
      expect_out("unused", 64'h11, 64'hC0, 1'b0, 1'b0, 1'b0); compare_out();
      use_rs2 = 1'b1;
      expect_out("used", 64'h11, 64'hC0, 1'b0, 1'b1, 1'b0); compare_out();

      // Flush clears pending; a same-cycle issue is dropped.
      step(); issue(5'd4);
      step(); rs1 = 5'd4; rf_rd1 = 64'h44; flush = 1'b1; issue(5'd4);
      expect_out("preflush", 64'h44, 64'h22, 1'b1, 1'b0, 1'b0); compare_out();
      step(); rs1 = 5'd4; rf_rd1 = 64'h44; rs2 = 5'd12; rf_rd2 = 64'hC0;
      expect_out("postflush", 64'h44, 64'hC0, 1'b0, 1'b0, 1'b0); compare_out();

      // Reset mid-flight.
      step(); issue(5'd4);
      step(); reset = 1'b0;
      step(); reset = 1'b1; rs1 = 5'd4; rf_rd1 = 64'h44;
      expect_out("postreset", 64'h44, 64'h22, 1'b0, 1'b0, 1'b0); compare_out();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
